// File: rtl/spec_mem_seq_pkg.sv
// Shared types and constants for the spec memory sequencer.
package spec_mem_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ_FST,
      WAIT_FST,
      REQ_SND,
      WAIT_SND,
      DONE
   } spec_mem_seq_state_e;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      BUS     = 2'd1,
      TIMEOUT = 2'd2,
      ILLEGAL = 2'd3
   } spec_mem_err_e;

   localparam logic [3:0] RdBe = 4'hF;

endpackage

// File: rtl/spec_mem_sequencer.sv
// Replays the spec instance's one- or two-granule memory side-effect onto an
// Ibex-style req/gnt/rvalid data bus and returns the read data and status.
module spec_mem_sequencer
   import spec_mem_seq_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        rd_i,
   input  logic        rd_snd_i,
   input  logic [31:0] rd_fst_addr_i,
   input  logic [31:0] rd_snd_addr_i,
   input  logic        wr_i,
   input  logic        wr_snd_i,
   input  logic [31:0] wr_fst_addr_i,
   input  logic [31:0] wr_snd_addr_i,
   input  logic [31:0] wr_fst_wdata_i,
   input  logic [31:0] wr_snd_wdata_i,
   input  logic [3:0]  wr_fst_be_i,
   input  logic [3:0]  wr_snd_be_i,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   input  logic [31:0] data_rdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [1:0]  err_cause_o,
   output logic [31:0] rd_fst_rdata_o,
   output logic [31:0] rd_snd_rdata_o
);

   localparam int unsigned    CntW   = $clog2(TimeoutCycles);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

   spec_mem_seq_state_e state_q, state_d;
   spec_mem_err_e       cause_q, cause_d;
   logic [CntW-1:0]     cnt_q;
   logic                timeout;

   logic        we_q, snd_q;
   logic [31:0] addr_fst_q, addr_snd_q;
   logic [31:0] wdata_fst_q, wdata_snd_q;
   logic [3:0]  be_fst_q, be_snd_q;
   logic [31:0] rdata_fst_q, rdata_snd_q;

   logic        in_req, snd_sel;

   assign timeout = (cnt_q == CntMax);

   // Next state; a gnt or rvalid in the final counted cycle still wins over timeout.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               cause_d = NONE;
               if (rd_i && wr_i) begin
                  state_d = DONE;
                  cause_d = ILLEGAL;
               end else if (!rd_i && !wr_i) begin
                  state_d = DONE;
               end else begin
                  state_d = REQ_FST;
               end
            end
         end
         REQ_FST, REQ_SND: begin
            if (data_gnt_i) begin
               state_d = (state_q == REQ_FST) ? WAIT_FST : WAIT_SND;
            end else if (timeout) begin
               state_d = DONE;
               cause_d = TIMEOUT;
            end
         end
         WAIT_FST, WAIT_SND: begin
            if (data_rvalid_i) begin
               if (data_err_i) begin
                  state_d = DONE;
                  cause_d = BUS;
               end else if (state_q == WAIT_FST && snd_q) begin
                  state_d = REQ_SND;
               end else begin
                  state_d = DONE;
               end
            end else if (timeout) begin
               state_d = DONE;
               cause_d = TIMEOUT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cause_q     <= NONE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         snd_q       <= 1'b0;
         addr_fst_q  <= '0;
         addr_snd_q  <= '0;
         wdata_fst_q <= '0;
         wdata_snd_q <= '0;
         be_fst_q    <= '0;
         be_snd_q    <= '0;
         rdata_fst_q <= '0;
         rdata_snd_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;

         if (state_d != state_q || state_q == IDLE) begin
            cnt_q <= '0;
         end else if (!timeout) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (state_q == IDLE && start_i) begin
            rdata_fst_q <= '0;
            rdata_snd_q <= '0;
            if (rd_i ^ wr_i) begin
               // A snd flag belonging to the other op is deliberately dropped here.
               we_q        <= wr_i;
               snd_q       <= wr_i ? wr_snd_i : rd_snd_i;
               addr_fst_q  <= wr_i ? wr_fst_addr_i : rd_fst_addr_i;
               addr_snd_q  <= wr_i ? wr_snd_addr_i : rd_snd_addr_i;
               wdata_fst_q <= wr_fst_wdata_i;
               wdata_snd_q <= wr_snd_wdata_i;
               be_fst_q    <= wr_fst_be_i;
               be_snd_q    <= wr_snd_be_i;
            end
         end

         if (data_rvalid_i && !we_q) begin
            if (state_q == WAIT_FST) rdata_fst_q <= data_rdata_i;
            if (state_q == WAIT_SND) rdata_snd_q <= data_rdata_i;
         end
      end
   end

   assign in_req  = (state_q == REQ_FST) || (state_q == REQ_SND);
   assign snd_sel = (state_q == REQ_SND);

   always_comb begin
      data_req_o   = in_req;
      data_addr_o  = '0;
      data_we_o    = 1'b0;
      data_be_o    = '0;
      data_wdata_o = '0;
      if (in_req) begin
         data_addr_o = snd_sel ? addr_snd_q : addr_fst_q;
         data_we_o   = we_q;
         if (we_q) begin
            data_be_o    = snd_sel ? be_snd_q : be_fst_q;
            data_wdata_o = snd_sel ? wdata_snd_q : wdata_fst_q;
         end else begin
            data_be_o = RdBe;
         end
      end
   end

   assign busy_o         = (state_q != IDLE);
   assign done_o         = (state_q == DONE);
   assign err_o          = done_o && (cause_q != NONE);
   assign err_cause_o    = done_o ? cause_q : NONE;
   assign rd_fst_rdata_o = rdata_fst_q;
   assign rd_snd_rdata_o = rdata_snd_q;

endmodule

// File: tb/tb_spec_mem_sequencer.sv
// Randomized bench: a transaction-level model predicts bus requests, timing and status.
module tb_spec_mem_sequencer;

   localparam int unsigned TO    = 8;
   localparam logic [7:0]  NEVER = 8'd99;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i, rd_i, rd_snd_i, wr_i, wr_snd_i;
   logic [31:0] rd_fst_addr_i, rd_snd_addr_i, wr_fst_addr_i, wr_snd_addr_i;
   logic [31:0] wr_fst_wdata_i, wr_snd_wdata_i;
   logic [3:0]  wr_fst_be_i, wr_snd_be_i;
   logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
   logic [3:0]  data_be_o;
   logic        busy_o, done_o, err_o;
   logic [1:0]  err_cause_o;
   logic [31:0] rd_fst_rdata_o, rd_snd_rdata_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   spec_mem_sequencer #(.TimeoutCycles(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .rd_i(rd_i), .rd_snd_i(rd_snd_i),
      .rd_fst_addr_i(rd_fst_addr_i), .rd_snd_addr_i(rd_snd_addr_i),
      .wr_i(wr_i), .wr_snd_i(wr_snd_i),
      .wr_fst_addr_i(wr_fst_addr_i), .wr_snd_addr_i(wr_snd_addr_i),
      .wr_fst_wdata_i(wr_fst_wdata_i), .wr_snd_wdata_i(wr_snd_wdata_i),
      .wr_fst_be_i(wr_fst_be_i), .wr_snd_be_i(wr_snd_be_i),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
      .data_addr_o(data_addr_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
      .data_rdata_i(data_rdata_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .err_cause_o(err_cause_o),
      .rd_fst_rdata_o(rd_fst_rdata_o), .rd_snd_rdata_o(rd_snd_rdata_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic            rd, wr, rd_snd, wr_snd;
      logic [1:0][31:0] rd_addr, wr_addr, wdata, rdata;
      logic [1:0][3:0]  be;
      logic [1:0][7:0]  gnt_dly, rv_dly;  // NEVER means the bus withholds it
      logic [1:0]       err;
   } txn_t;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_req"},   data_req_o, 0);
      chk({pfx, "_addr"},  data_addr_o, 0);
      chk({pfx, "_we"},    data_we_o, 0);
      chk({pfx, "_be"},    data_be_o, 0);
      chk({pfx, "_wdata"}, data_wdata_o, 0);
      chk({pfx, "_busy"},  busy_o, 0);
      chk({pfx, "_done"},  done_o, 0);
      chk({pfx, "_err"},   err_o, 0);
      chk({pfx, "_cause"}, err_cause_o, 0);
      chk({pfx, "_rd0"},   rd_fst_rdata_o, 0);
      chk({pfx, "_rd1"},   rd_snd_rdata_o, 0);
   endtask

   task automatic chk_req(input logic [31:0] ea, input logic ewe, input logic [3:0] eb,
                          input logic [31:0] ewd);
      chk("req",       data_req_o, 1);
      chk("req_addr",  data_addr_o, ea);
      chk("req_we",    data_we_o, ewe);
      chk("req_be",    data_be_o, eb);
      chk("req_wdata", data_wdata_o, ewd);
   endtask

   // Spec inputs are only meaningful in the start cycle; garble them afterwards.
   task automatic scramble();
      rd_i = 1'($urandom); wr_i = 1'($urandom);
      rd_snd_i = 1'($urandom); wr_snd_i = 1'($urandom);
      rd_fst_addr_i = $urandom; rd_snd_addr_i = $urandom;
      wr_fst_addr_i = $urandom; wr_snd_addr_i = $urandom;
      wr_fst_wdata_i = $urandom; wr_snd_wdata_i = $urandom;
      wr_fst_be_i = 4'($urandom); wr_snd_be_i = 4'($urandom);
   endtask

   task automatic run_txn(input txn_t t);
      logic [1:0][31:0] exp_rd;
      logic [1:0]       exp_cause;
      logic [31:0]      ea, ewd;
      logic [3:0]       eb;
      int               ng;
      bit               stop;
      exp_rd = '0; exp_cause = 2'd0; stop = 1'b0;
      @(negedge clk_i);
      start_i = 1'b1;
      rd_i = t.rd; wr_i = t.wr; rd_snd_i = t.rd_snd; wr_snd_i = t.wr_snd;
      rd_fst_addr_i = t.rd_addr[0]; rd_snd_addr_i = t.rd_addr[1];
      wr_fst_addr_i = t.wr_addr[0]; wr_snd_addr_i = t.wr_addr[1];
      wr_fst_wdata_i = t.wdata[0]; wr_snd_wdata_i = t.wdata[1];
      wr_fst_be_i = t.be[0]; wr_snd_be_i = t.be[1];
      @(negedge clk_i);
      start_i = 1'b0;
      scramble();
      if (t.rd == t.wr) begin
         exp_cause = t.rd ? 2'd3 : 2'd0;
      end else begin
         ng = (t.wr ? t.wr_snd : t.rd_snd) ? 2 : 1;
         for (int g = 0; g < ng && !stop; g++) begin
            ea  = t.wr ? t.wr_addr[g] : t.rd_addr[g];
            eb  = t.wr ? t.be[g] : 4'hF;
            ewd = t.wr ? t.wdata[g] : 32'h0;
            chk_req(ea, t.wr, eb, ewd);
            if (t.gnt_dly[g] >= TO) begin
               repeat (TO) @(negedge clk_i);
               exp_cause = 2'd2; stop = 1'b1;
            end else begin
               for (int k = 0; k < int'(t.gnt_dly[g]); k++) begin
                  data_rvalid_i = (k == 0);
                  data_rdata_i  = $urandom;
                  @(negedge clk_i);
                  data_rvalid_i = 1'b0;
                  chk_req(ea, t.wr, eb, ewd);
               end
               data_gnt_i = 1'b1;
               @(negedge clk_i);
               data_gnt_i = 1'b0;
               chk("req_drop", data_req_o, 0);
               if (t.rv_dly[g] >= TO) begin
                  repeat (TO) @(negedge clk_i);
                  exp_cause = 2'd2; stop = 1'b1;
               end else begin
                  repeat (int'(t.rv_dly[g])) @(negedge clk_i);
                  data_rvalid_i = 1'b1;
                  data_rdata_i  = t.rdata[g];
                  data_err_i    = t.err[g];
                  @(negedge clk_i);
                  data_rvalid_i = 1'b0;
                  data_err_i    = 1'b0;
                  data_rdata_i  = $urandom;
                  if (!t.wr) exp_rd[g] = t.rdata[g];
                  if (t.err[g]) begin
                     exp_cause = 2'd1; stop = 1'b1;
                  end
               end
            end
         end
      end
      chk("done",      done_o, 1);
      chk("done_req",  data_req_o, 0);
      chk("err",       err_o, (exp_cause != 2'd0));
      chk("cause",     err_cause_o, exp_cause);
      chk("rdata_fst", rd_fst_rdata_o, exp_rd[0]);
      chk("rdata_snd", rd_snd_rdata_o, exp_rd[1]);
      @(negedge clk_i);
      chk("done_pulse", done_o, 0);
      chk("idle_busy",  busy_o, 0);
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      int unsigned op;
      t = '0;
      op = $urandom_range(0, 9);
      t.rd = (op == 0) || (op >= 2 && op <= 5);
      t.wr = (op == 0) || (op >= 6);
      t.rd_snd = 1'($urandom);
      t.wr_snd = 1'($urandom);
      for (int g = 0; g < 2; g++) begin
         t.rd_addr[g] = $urandom;
         t.wr_addr[g] = $urandom;
         t.wdata[g]   = $urandom;
         t.rdata[g]   = $urandom;
         t.be[g]      = 4'($urandom);
         t.gnt_dly[g] = ($urandom_range(0, 19) == 0) ? NEVER : 8'($urandom_range(0, 3));
         t.rv_dly[g]  = ($urandom_range(0, 19) == 0) ? NEVER : 8'($urandom_range(0, 3));
         t.err[g]     = ($urandom_range(0, 6) == 0);
      end
      return t;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      txn_t t;
      rst_ni = 1'b0; start_i = 1'b0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
      scramble();
      repeat (2) @(negedge clk_i);
      chk_outputs_zero("rst");
      rst_ni = 1'b1;

      // Aligned read, zero-wait bus.
      t = '0; t.rd = 1'b1; t.rd_addr[0] = 32'h100; t.rdata[0] = 32'hDEADBEEF;
      run_txn(t);

      // Misaligned write with delayed grants.
      t = '0; t.wr = 1'b1; t.wr_snd = 1'b1;
      t.wr_addr = {32'h104, 32'h103}; t.be = {4'h7, 4'h8};
      t.wdata = {32'h00223344, 32'h11000000}; t.gnt_dly = {8'd3, 8'd3};
      run_txn(t);

      // Bus error on the first granule of a two-granule read.
      t = '0; t.rd = 1'b1; t.rd_snd = 1'b1; t.rd_addr = {32'h204, 32'h202};
      t.err[0] = 1'b1; t.rdata[0] = 32'hA5A5A5A5;
      run_txn(t);

      // Illegal, no-op and invalid-snd-only requests.
      t = '0; t.rd = 1'b1; t.wr = 1'b1; run_txn(t);
      t = '0; t.rd_snd = 1'b1; t.wr_snd = 1'b1; run_txn(t);
      t = '0; t.rd = 1'b1; t.wr_snd = 1'b1; t.rd_addr[0] = 32'h40; t.rdata[0] = 32'h1234;
      run_txn(t);

      // Grant and rvalid timeouts.
      t = '0; t.rd = 1'b1; t.rd_addr[0] = 32'h300; t.gnt_dly[0] = NEVER; run_txn(t);
      t = '0; t.wr = 1'b1; t.wr_snd = 1'b1; t.wr_addr = {32'h8, 32'h4};
      t.be = {4'h3, 4'hC}; t.rv_dly[1] = NEVER; run_txn(t);

      // Reset while waiting for the second read response.
      @(negedge clk_i);
      start_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; rd_snd_i = 1'b1;
      rd_fst_addr_i = 32'h500; rd_snd_addr_i = 32'h504;
      @(negedge clk_i);
      start_i = 1'b0; data_gnt_i = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
      @(negedge clk_i);
      data_rvalid_i = 1'b0; data_gnt_i = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      chk("pre_rst_busy", busy_o, 1);
      chk("pre_rst_rd0",  rd_fst_rdata_o, 32'h12345678);
      #2 rst_ni = 1'b0;
      #1 chk_outputs_zero("async_rst");
      @(negedge clk_i);
      rst_ni = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0BAD0;
      @(negedge clk_i);
      data_rvalid_i = 1'b0;
      chk_outputs_zero("stray_rvalid");

      for (int i = 0; i < 300; i++) run_txn(rand_txn());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
